jk_reg_bank: RTL and testbench

- Parametrised multi-bit register built on JK flip-flop semantics, with four selectable operating modes: per-bit JK, D, T, and modulo up/down counter.
- Successor to the single-bit JK flip-flop. Used wherever the design needs a bank of JK/D/T storage bits, or a small synchronous counter with terminal-count detection.
- One instance replaces WIDTH discrete flip-flops plus external counter glue.

---
 rtl/jk_reg_bank.sv | 118 +++++++++++
 tb/tb_jk_reg_bank.sv | 112 +++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit register bank built on JK flip-flop semantics.
// There are four operating modes:
//   JK    (00) - per-bit JK using j/k
//   D     (01) - q <= j
//   T     (10) - q <= q ^ j
//   COUNT (11) - modulo-MOD up/down counter, direction set by dir
//
// The priority on each rising edge is rst > load > en.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset, loads RST_VAL
//   en       - state-update enable (load still acts when en=0)
//   mode     - operating mode select
//   j, k     - JK inputs; j is also the D data and the T toggle mask
//   dir      - count direction in COUNT mode (1 = up)
//   load     - synchronous parallel load strobe
//   load_val - value for load
//   q        - registered state
//   q_bar    - ~q, combinational
//   tc       - terminal-count flag, combinational from q/mode/dir/en

// Next-state logic for one JK bit.
module jk_reg_bank_cell (
    input  logic q,
    input  logic j,
    input  logic k,
    output logic nq
);
    always_comb begin
        unique case ({j, k})
            2'b00:   nq = q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~q;
        endcase
    end
endmodule

module jk_reg_bank #(
    parameter int               WIDTH   = 4,
    parameter int               MOD     = 10,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);
    localparam logic [1:0] M_JK    = 2'b00;
    localparam logic [1:0] M_D     = 2'b01;
    localparam logic [1:0] M_T     = 2'b10;
    localparam logic [1:0] M_COUNT = 2'b11;

    // The modulus may equal 2^WIDTH, so the extended copy carries one extra bit.
    localparam logic [WIDTH-1:0] MOD_M1  = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);

    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("jk_reg_bank: MOD out of range 2..2^WIDTH");
    end

    logic [WIDTH-1:0] jk_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] nxt;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_reg_bank_cell u_cell (
            .q  (q[g]),
            .j  (j[g]),
            .k  (k[g]),
            .nq (jk_nxt[g])
        );
    end

    // Counter step. An out-of-range q (reached via load/JK/D/T/RST_VAL) snaps
    // back into 0..MOD-1 on the first COUNT step.
    always_comb begin
        cnt_nxt = q;
        if (dir) begin
            if (q >= MOD_M1) cnt_nxt = '0;
            else             cnt_nxt = q + WIDTH'(1);
        end else begin
            if (q == '0 || {1'b0, q} >= MOD_EXT) cnt_nxt = MOD_M1;
            else                                 cnt_nxt = q - WIDTH'(1);
        end
    end

    always_comb begin
        nxt = q;
        unique case (mode)
            M_JK:    nxt = jk_nxt;
            M_D:     nxt = j;
            M_T:     nxt = q ^ j;
            default: nxt = cnt_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)       q <= RST_VAL;
        else if (load) q <= load_val;
        else if (en)   q <= nxt;
    end

    assign q_bar = ~q;

    // tc is deliberately not gated by load or rst.
    assign tc = en && (mode == M_COUNT) && (dir ? (q == MOD_M1) : (q == '0));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank (WIDTH=4, MOD=10, RST_VAL=5).
module tb_jk_reg_bank;
    logic       clk = 1'b0;
    logic       rst, en, dir, load;
    logic [1:0] mode;
    logic [3:0] j, k, load_val;
    logic [3:0] q, q_bar;
    logic       tc;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    jk_reg_bank #(.WIDTH(4), .MOD(10), .RST_VAL(4'h5)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .j        (j),
        .k        (k),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .q_bar    (q_bar),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] eq, input logic etc);
        total++;
        assert (q === eq) else begin
            bad++;
            $error("FAIL %s q: got %h want %h", tag, q, eq);
        end
        total++;
        assert (q_bar === ~eq) else begin
            bad++;
            $error("FAIL %s q_bar: got %h want %h", tag, q_bar, ~eq);
        end
        total++;
        assert (tc === etc) else begin
            bad++;
            $error("FAIL %s tc: got %b want %b", tag, tc, etc);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the expected
    // state. After the next rising edge, pop that entry and compare.
    task automatic step(input string tag, input logic r, input logic ld,
                        input logic [3:0] lv, input logic e, input logic [1:0] m,
                        input logic [3:0] jj, input logic [3:0] kk, input logic d,
                        input logic [3:0] eq, input logic etc);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; load_val = lv; en = e; mode = m;
        j = jj; k = kk; dir = d;
        sb.push_back('{tag, eq, etc});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check(x.tag, x.q, x.tc);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b1; mode = 2'b11;
        j = '0; k = '0; dir = 1'b1;

        //   tag          rst ld lv    en mode   j     k     dir  q     tc
        step("rst0",      1, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 1,  4'h5, 0);
        step("rst1",      1, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 1,  4'h5, 0);
        step("cnt_rst",   0, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 1,  4'h6, 0);
        step("ld5",       0, 1, 4'h5, 1, 2'b00, 4'h0, 4'h0, 1,  4'h5, 0);
        step("jk",        0, 0, 4'h0, 1, 2'b00, 4'hC, 4'hA, 1,  4'hD, 0);
        step("jk_hold",   0, 0, 4'h0, 0, 2'b00, 4'hF, 4'h0, 1,  4'hD, 0);
        step("d9",        0, 0, 4'h0, 1, 2'b01, 4'h9, 4'h0, 1,  4'h9, 0);
        step("t3",        0, 0, 4'h0, 1, 2'b10, 4'h3, 4'h0, 1,  4'hA, 0);
        step("t0",        0, 0, 4'h0, 1, 2'b10, 4'h0, 4'h0, 1,  4'hA, 0);
        step("ld8_cnt",   0, 1, 4'h8, 1, 2'b11, 4'h0, 4'h0, 1,  4'h8, 0);
        step("up9",       0, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 1,  4'h9, 1);
        step("up0",       0, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 1,  4'h0, 0);
        step("up1",       0, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 1,  4'h1, 0);
        step("dn0",       0, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 0,  4'h0, 1);
        step("dn9",       0, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 0,  4'h9, 0);
        step("ldE",       0, 1, 4'hE, 1, 2'b11, 4'h0, 4'h0, 0,  4'hE, 0);
        step("dn_oor",    0, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 0,  4'h9, 0);
        step("ldF",       0, 1, 4'hF, 1, 2'b11, 4'h0, 4'h0, 1,  4'hF, 0);
        step("up_oor",    0, 0, 4'h0, 1, 2'b11, 4'h0, 4'h0, 1,  4'h0, 0);
        step("rst_vs_ld", 1, 1, 4'h3, 1, 2'b11, 4'h0, 4'h0, 1,  4'h5, 0);
        step("ld_en0",    0, 1, 4'h3, 0, 2'b00, 4'h0, 4'h0, 1,  4'h3, 0);
        step("ld9_en0",   0, 1, 4'h9, 0, 2'b11, 4'h0, 4'h0, 1,  4'h9, 0);

        // tc is combinational: raise en without an edge and expect tc at once.
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        #1;
        check("tc_comb_en", 4'h9, 1'b1);
        dir = 1'b0;
        #1;
        check("tc_comb_dir", 4'h9, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
